uart_load_ctrl: RTL and testbench

Packet controller placed after the UART receiver. It consumes the receiver's byte stream (data-valid pulse plus byte). It parses framed load packets, assembles little-endian 32-bit words, and writes them into a word-addressed memory port through a valid/ready handshake. While a load is in progress it holds the CPU off, and it reports completion or a coded error.

---
 rtl/uart_load_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_load_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_load_ctrl
// Description : Parses framed UART load packets into 32-bit memory writes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_load_ctrl #(
    parameter int          ADDR_W       = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 100000
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Mem_We,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [31:0]       o_Mem_Wdata,
    input  logic              i_Mem_Ready,
    output logic              o_Load_Busy,
    output logic              o_Done,
    output logic [1:0]        o_Err_Code
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ADDR_H = 3'd1;
    localparam logic [2:0] c_ADDR_L = 3'd2;
    localparam logic [2:0] c_LEN    = 3'd3;
    localparam logic [2:0] c_DATA   = 3'd4;
    localparam logic [2:0] c_CHK    = 3'd5;
    localparam logic [2:0] c_DRAIN  = 3'd6;

    localparam int                c_TMO_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CLKS - 1);

    logic [2:0]         r_state,     w_nxt_state;
    logic               r_mem_we,    w_nxt_we;
    logic [ADDR_W-1:0]  r_mem_addr,  w_nxt_mem_addr;
    logic [31:0]        r_mem_wdata, w_nxt_wdata;
    logic               r_busy,      w_nxt_busy;
    logic               r_done,      w_nxt_done;
    logic [1:0]         r_err,       w_nxt_err;
    logic [7:0]         r_chk,       w_nxt_chk;
    logic [7:0]         r_addr_h,    w_nxt_addr_h;
    logic [ADDR_W-1:0]  r_base,      w_nxt_base;
    logic [8:0]         r_word_cnt,  w_nxt_cnt;
    logic [1:0]         r_lane,      w_nxt_lane;
    logic [23:0]        r_shift,     w_nxt_shift;
    logic [c_TMO_W-1:0] r_tmo,       w_nxt_tmo;

    logic               w_we_hold;
    logic               w_counting;
    logic [7:0]         w_chk_upd;
    logic [15:0]        w_addr_raw;
    logic [ADDR_W-1:0]  w_addr_load;

    // A pending write survives this edge only if memory does not take it now
    assign w_we_hold  = r_mem_we & ~i_Mem_Ready;
    assign w_counting = (r_state != c_IDLE) && (r_state != c_DRAIN);
    assign w_chk_upd  = r_chk ^ i_Rx_Byte;
    assign w_addr_raw = {r_addr_h, i_Rx_Byte};

    generate
        if (ADDR_W <= 16) begin : g_addr_trunc
            assign w_addr_load = w_addr_raw[ADDR_W-1:0];
        end else begin : g_addr_ext
            assign w_addr_load = {{(ADDR_W-16){1'b0}}, w_addr_raw};
        end
    endgenerate

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_we       = w_we_hold;
        w_nxt_mem_addr = r_mem_addr;
        w_nxt_wdata    = r_mem_wdata;
        w_nxt_busy     = r_busy;
        w_nxt_done     = 1'b0;
        w_nxt_err      = r_err;
        w_nxt_chk      = r_chk;
        w_nxt_addr_h   = r_addr_h;
        w_nxt_base     = r_base;
        w_nxt_cnt      = r_word_cnt;
        w_nxt_lane     = r_lane;
        w_nxt_shift    = r_shift;
        w_nxt_tmo      = '0;
        if (!i_Rx_DV && w_counting) begin
            w_nxt_tmo = r_tmo + c_TMO_W'(1);
        end

        case (r_state)
            c_IDLE: begin
                // Busy may still be held by a write left over from a checksum error
                if (r_busy && !w_we_hold) begin
                    w_nxt_busy = 1'b0;
                end
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    w_nxt_state = c_ADDR_H;
                    w_nxt_busy  = 1'b1;
                    w_nxt_err   = 2'b00;
                    w_nxt_chk   = 8'h00;
                end
            end
            c_ADDR_H: begin
                if (i_Rx_DV) begin
                    w_nxt_addr_h = i_Rx_Byte;
                    w_nxt_chk    = w_chk_upd;
                    w_nxt_state  = c_ADDR_L;
                end
            end
            c_ADDR_L: begin
                if (i_Rx_DV) begin
                    w_nxt_base  = w_addr_load;
                    w_nxt_chk   = w_chk_upd;
                    w_nxt_state = c_LEN;
                end
            end
            c_LEN: begin
                if (i_Rx_DV) begin
                    w_nxt_cnt   = (i_Rx_Byte == 8'h00) ? 9'd256 : {1'b0, i_Rx_Byte};
                    w_nxt_lane  = 2'd0;
                    w_nxt_chk   = w_chk_upd;
                    w_nxt_state = c_DATA;
                end
            end
            c_DATA: begin
                if (i_Rx_DV) begin
                    w_nxt_chk = w_chk_upd;
                    if (r_lane != 2'd3) begin
                        w_nxt_shift = {i_Rx_Byte, r_shift[23:8]};
                        w_nxt_lane  = r_lane + 2'd1;
                    end else if (w_we_hold) begin
                        w_nxt_err   = 2'b11;
                        w_nxt_we    = 1'b0;
                        w_nxt_busy  = 1'b0;
                        w_nxt_state = c_IDLE;
                    end else begin
                        w_nxt_we       = 1'b1;
                        w_nxt_mem_addr = r_base;
                        w_nxt_wdata    = {i_Rx_Byte, r_shift};
                        w_nxt_base     = r_base + ADDR_W'(1);
                        w_nxt_cnt      = r_word_cnt - 9'd1;
                        w_nxt_lane     = 2'd0;
                        if (r_word_cnt == 9'd1) begin
                            w_nxt_state = c_CHK;
                        end
                    end
                end
            end
            c_CHK: begin
                if (i_Rx_DV) begin
                    w_nxt_state = c_IDLE;
                    if (i_Rx_Byte != r_chk) begin
                        w_nxt_err  = 2'b01;
                        w_nxt_busy = w_we_hold;
                    end else if (w_we_hold) begin
                        w_nxt_state = c_DRAIN;
                    end else begin
                        w_nxt_done = 1'b1;
                        w_nxt_busy = 1'b0;
                    end
                end
            end
            c_DRAIN: begin
                if (!w_we_hold) begin
                    w_nxt_done  = 1'b1;
                    w_nxt_busy  = 1'b0;
                    w_nxt_state = c_IDLE;
                end
            end
            default: begin
                w_nxt_state = c_IDLE;
            end
        endcase

        // A byte arriving on the terminal count takes priority over the abort
        if (w_counting && !i_Rx_DV && (r_tmo == c_TMO_LAST)) begin
            w_nxt_err   = 2'b10;
            w_nxt_we    = 1'b0;
            w_nxt_busy  = 1'b0;
            w_nxt_state = c_IDLE;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state     <= c_IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 2'b00;
            r_chk       <= 8'h00;
            r_addr_h    <= 8'h00;
            r_base      <= '0;
            r_word_cnt  <= 9'd0;
            r_lane      <= 2'd0;
            r_shift     <= 24'h0;
            r_tmo       <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_mem_we    <= w_nxt_we;
            r_mem_addr  <= w_nxt_mem_addr;
            r_mem_wdata <= w_nxt_wdata;
            r_busy      <= w_nxt_busy;
            r_done      <= w_nxt_done;
            r_err       <= w_nxt_err;
            r_chk       <= w_nxt_chk;
            r_addr_h    <= w_nxt_addr_h;
            r_base      <= w_nxt_base;
            r_word_cnt  <= w_nxt_cnt;
            r_lane      <= w_nxt_lane;
            r_shift     <= w_nxt_shift;
            r_tmo       <= w_nxt_tmo;
        end
    end

    assign o_Mem_We    = r_mem_we;
    assign o_Mem_Addr  = r_mem_addr;
    assign o_Mem_Wdata = r_mem_wdata;
    assign o_Load_Busy = r_busy;
    assign o_Done      = r_done;
    assign o_Err_Code  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_load_ctrl
// Description : Scoreboard bench for uart_load_ctrl with a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_load_ctrl;

    localparam int         c_TMO  = 64;
    localparam logic [7:0] c_SYNC = 8'hA5;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic        r_rx_dv;
    logic [7:0]  r_rx_byte;
    logic        r_ready;
    logic        w_we;
    logic [15:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_busy;
    logic        w_done;
    logic [1:0]  w_err;

    always #5 r_clk = ~r_clk;

    uart_load_ctrl #(
        .ADDR_W       (16),
        .SYNC_BYTE    (c_SYNC),
        .TIMEOUT_CLKS (c_TMO)
    ) u_dut (
        .i_Clock     (r_clk),
        .i_Reset     (r_rst),
        .i_Rx_DV     (r_rx_dv),
        .i_Rx_Byte   (r_rx_byte),
        .o_Mem_We    (w_we),
        .o_Mem_Addr  (w_addr),
        .o_Mem_Wdata (w_wdata),
        .i_Mem_Ready (r_ready),
        .o_Load_Busy (w_busy),
        .o_Done      (w_done),
        .o_Err_Code  (w_err)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks    = 0;
    int  errors    = 0;
    int  cyc       = 0;
    int  done_seen = 0;
    int  done_cyc  = -1;
    int  last_acc  = -1;
    int  rdy_mode  = 0;
    int  rdy_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory side: 0 = always ready, 1 = 20 cycles of back-pressure per request, 2 = never ready
    initial begin
        r_ready = 1'b1;
        forever begin
            @(posedge r_clk);
            #2;
            case (rdy_mode)
                0: r_ready = 1'b1;
                1: begin
                    if (w_we) begin
                        rdy_cnt++;
                        r_ready = (rdy_cnt > 20);
                    end else begin
                        rdy_cnt = 0;
                        r_ready = 1'b0;
                    end
                end
                default: r_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every accepted write is popped from the scoreboard
    initial begin
        wr_t e;
        forever begin
            @(negedge r_clk);
            cyc++;
            if (w_we === 1'b1 && r_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected none", w_addr, w_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (w_addr !== e.a || w_wdata !== e.d) begin
                        errors++;
                        $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                                 w_addr, w_wdata, e.a, e.d);
                    end
                end
                last_acc = cyc;
            end
            if (w_done === 1'b1) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        r_rx_dv   = 1'b1;
        r_rx_byte = b;
        @(negedge r_clk);
        r_rx_dv = 1'b0;
        repeat (gap) @(negedge r_clk);
    endtask

    // Reference model: expected writes are base+i (mod 2^16), little-endian words, XOR checksum
    task automatic send_packet(input logic [15:0] addr, input int len, input int gap, input int tail_gap,
                               input bit bad, input int n_noise, input bit fixed, input logic [31:0] fword,
                               output logic [1:0] e_err, output int e_done);
        logic [7:0]  chk;
        logic [7:0]  lenb;
        logic [31:0] word;
        logic [7:0]  by;
        wr_t         e;
        chk  = 8'h00;
        lenb = len[7:0];
        for (int i = 0; i < n_noise; i++) send_byte(8'h3C, gap);
        send_byte(c_SYNC, gap);
        send_byte(addr[15:8], gap);
        chk ^= addr[15:8];
        send_byte(addr[7:0], gap);
        chk ^= addr[7:0];
        send_byte(lenb, gap);
        chk ^= lenb;
        for (int w = 0; w < len; w++) begin
            word = fixed ? fword : $urandom;
            e.a  = addr + 16'(w);
            e.d  = word;
            exp_q.push_back(e);
            for (int b = 0; b < 4; b++) begin
                by = word[8*b +: 8];
                chk ^= by;
                send_byte(by, (w == len - 1 && b == 3) ? tail_gap : gap);
            end
        end
        send_byte(bad ? (chk ^ 8'h03) : chk, 0);
        e_err  = bad ? 2'b01 : 2'b00;
        e_done = bad ? 0 : 1;
    endtask

    task automatic finish_packet(input string tag, input logic [1:0] e_err, input int e_done);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || w_busy !== 1'b0) && n < 4000) begin
            @(negedge r_clk);
            n++;
        end
        check({tag, "_completion_bound"}, (n < 4000), 1'b1);
        repeat (2) @(negedge r_clk);
        check({tag, "_err"},  w_err,     e_err);
        check({tag, "_done"}, done_seen, e_done);
        check({tag, "_busy"}, w_busy,    1'b0);
        check({tag, "_we"},   w_we,      1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [1:0] ee;
        int         ed;
        r_rst     = 1'b1;
        r_rx_dv   = 1'b0;
        r_rx_byte = 8'h00;
        repeat (3) @(negedge r_clk);
        check("reset_we",    w_we,    1'b0);
        check("reset_addr",  w_addr,  16'h0);
        check("reset_wdata", w_wdata, 32'h0);
        check("reset_busy",  w_busy,  1'b0);
        check("reset_done",  w_done,  1'b0);
        check("reset_err",   w_err,   2'b00);
        r_rst = 1'b0;
        repeat (2) @(negedge r_clk);

        // Good packet A5 00 10 01 11 22 33 44 55
        done_seen = 0;
        send_packet(16'h0010, 1, 0, 0, 1'b0, 0, 1'b1, 32'h44332211, ee, ed);
        finish_packet("good", ee, ed);

        // Noise then bad checksum
        done_seen = 0;
        send_packet(16'h0010, 1, 0, 0, 1'b1, 1, 1'b1, 32'h44332211, ee, ed);
        finish_packet("badchk", ee, ed);

        // Address wrap with back-pressure; checksum lands while the last write is pending
        rdy_mode  = 1;
        done_seen = 0;
        send_packet(16'hFFFF, 2, 25, 0, 1'b0, 0, 1'b0, 32'h0, ee, ed);
        finish_packet("wrap", ee, ed);
        check("drain_done_timing", done_cyc, last_acc + 1);

        // Bad checksum with a pending write: busy held until it drains
        done_seen = 0;
        send_packet(16'h0200, 1, 2, 0, 1'b1, 0, 1'b0, 32'h0, ee, ed);
        check("badchk_pending_busy", w_busy, 1'b1);
        check("badchk_pending_err",  w_err,  2'b01);
        finish_packet("badchk_pending", ee, ed);
        rdy_mode = 0;

        // Overrun: memory never ready
        rdy_mode = 2;
        repeat (2) @(negedge r_clk);
        send_byte(c_SYNC, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i + 1), 0);
            if (i == 3) check("overrun_first_pending", w_we, 1'b1);
        end
        check("overrun_err",  w_err,  2'b11);
        check("overrun_we",   w_we,   1'b0);
        check("overrun_busy", w_busy, 1'b0);
        rdy_mode = 0;
        repeat (5) @(negedge r_clk);

        // Timeout after A5 00, with exact terminal-count boundary
        send_byte(c_SYNC, 0);
        send_byte(8'h00, 0);
        repeat (c_TMO - 1) @(negedge r_clk);
        check("timeout_busy_before", w_busy, 1'b1);
        check("timeout_err_before",  w_err,  2'b00);
        @(negedge r_clk);
        check("timeout_busy_after", w_busy, 1'b0);
        check("timeout_err_after",  w_err,  2'b10);

        // Recovery packet clears the sticky error
        done_seen = 0;
        send_packet(16'h0300, 2, 1, 1, 1'b0, 0, 1'b0, 32'h0, ee, ed);
        finish_packet("recover", ee, ed);

        // Every byte lands exactly on the terminal count: byte wins
        done_seen = 0;
        send_packet(16'h0400, 1, c_TMO - 1, c_TMO - 1, 1'b0, 0, 1'b0, 32'h0, ee, ed);
        finish_packet("tmo_edge", ee, ed);

        // LEN=0 means 256 words
        done_seen = 0;
        send_packet(16'hFF80, 256, 0, 0, 1'b0, 0, 1'b0, 32'h0, ee, ed);
        finish_packet("len256", ee, ed);

        // Randomized packets
        for (int p = 0; p < 8; p++) begin
            done_seen = 0;
            send_packet(16'($urandom), $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 1'b0, 32'h0, ee, ed);
            finish_packet("random", ee, ed);
        end

        // Reset during DATA with a write pending
        rdy_mode = 2;
        repeat (2) @(negedge r_clk);
        send_byte(c_SYNC, 0);
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        check("prereset_we", w_we, 1'b1);
        #1 r_rst = 1'b1;
        #1;
        check("async_reset_we",    w_we,    1'b0);
        check("async_reset_addr",  w_addr,  16'h0);
        check("async_reset_wdata", w_wdata, 32'h0);
        check("async_reset_busy",  w_busy,  1'b0);
        check("async_reset_done",  w_done,  1'b0);
        check("async_reset_err",   w_err,   2'b00);
        @(negedge r_clk);
        r_rst    = 1'b0;
        rdy_mode = 0;
        send_byte(8'h66, 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        send_byte(8'h12, 0);
        repeat (10) @(negedge r_clk);
        check("post_reset_busy", w_busy, 1'b0);
        check("post_reset_we",   w_we,   1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
